fifo_sync_buffer: RTL and testbench

- Single-clock, parametrised FIFO buffer with full pointer and occupancy control; successor to the bare FIFO memory array.
- Supports arbitrary, non-power-of-two depth with explicit pointer wrap.
- Adds a registered read port, occupancy count, almost-full/almost-empty thresholds and overflow/underflow reporting.
- Sits between a single-clock producer and consumer where no clock-domain crossing is needed.

---
 rtl/fifo_sync_buffer.sv | 121 ++++++++++++
 tb/tb_fifo_sync_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_buffer.sv
// Single-clock FIFO with arbitrary depth, registered read port, occupancy and threshold flags.
// Define FIFO_STICKY_ERR_EN to make OVERFLOW/UNDERFLOW sticky until ERR_CLR or reset.
module fifo_sync_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 333,
  parameter int unsigned AF_THRESH  = MEM_DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
  localparam int unsigned PTR_WIDTH = $clog2(MEM_DEPTH),
  localparam int unsigned CNT_WIDTH = $clog2(MEM_DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  W_EN,
  input  logic [DATA_WIDTH-1:0] I_DATA,
  input  logic                  R_EN,
  input  logic                  ERR_CLR,
  output logic [DATA_WIDTH-1:0] O_DATA,
  output logic                  O_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [CNT_WIDTH-1:0]  COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam logic [PTR_WIDTH-1:0] LastPtr = PTR_WIDTH'(MEM_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0]  rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic full, empty, wr_ok, rd_ok, ovf_ev, udf_ev;

  // Flags decode only the registered count, so no request input reaches an output.
  assign full  = (count_q == CNT_WIDTH'(MEM_DEPTH));
  assign empty = (count_q == '0);

  assign wr_ok  = W_EN & ~full;
  assign rd_ok  = R_EN & ~empty;
  assign ovf_ev = W_EN & full;
  assign udf_ev = R_EN & empty;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = rd_ok;

    if (wr_ok) begin
      wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PTR_WIDTH'(1);
    end
    if (rd_ok) begin
      rptr_d  = (rptr_q == LastPtr) ? '0 : rptr_q + PTR_WIDTH'(1);
      rdata_d = mem_q[rptr_q];
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef FIFO_STICKY_ERR_EN
  // A new error in the same cycle as ERR_CLR wins.
  assign ovf_d = ovf_ev | (ovf_q & ~ERR_CLR);
  assign udf_d = udf_ev | (udf_q & ~ERR_CLR);
`else
  logic unused_err_clr;
  assign unused_err_clr = ERR_CLR;
  assign ovf_d = ovf_ev;
  assign udf_d = udf_ev;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem_q[wptr_q] <= I_DATA;
    end
  end

  assign O_DATA       = rdata_q;
  assign O_VALID      = rvalid_q;
  assign FULL         = full;
  assign EMPTY        = empty;
  assign ALMOST_FULL  = (count_q >= CNT_WIDTH'(AF_THRESH));
  assign ALMOST_EMPTY = (count_q <= CNT_WIDTH'(AE_THRESH));
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_fifo_sync_buffer.sv
// Self-checking bench for fifo_sync_buffer at depth 5: queue-based model plus directed literals.
module tb_fifo_sync_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AFT   = DEPTH - 2;
  localparam int AET   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic [DW-1:0] o_data;
  logic          o_valid, full, empty, afull, aempty, ovf, udf;
  logic [CW-1:0] count;

  int n_pass = 0;
  int n_total = 0;

  fifo_sync_buffer #(
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH),
    .AF_THRESH (AFT),
    .AE_THRESH (AET)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .W_EN        (w_en),
    .I_DATA      (i_data),
    .R_EN        (r_en),
    .ERR_CLR     (err_clr),
    .O_DATA      (o_data),
    .O_VALID     (o_valid),
    .FULL        (full),
    .EMPTY       (empty),
    .ALMOST_FULL (afull),
    .ALMOST_EMPTY(aempty),
    .COUNT       (count),
    .OVERFLOW    (ovf),
    .UNDERFLOW   (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: contents as a queue, outputs derived from its size.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] m_odata;
  logic          m_ovalid, m_ovf, m_udf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
      m_odata  <= '0;
      m_ovalid <= 1'b0;
      m_ovf    <= 1'b0;
      m_udf    <= 1'b0;
    end else begin
      automatic int  sz     = model_q.size();
      automatic bit  is_full  = (sz == DEPTH);
      automatic bit  is_empty = (sz == 0);
      automatic bit  do_rd  = r_en && !is_empty;
      automatic bit  do_wr  = w_en && !is_full;
      automatic bit  ov_ev  = w_en && is_full;
      automatic bit  un_ev  = r_en && is_empty;
      if (do_rd) m_odata <= model_q.pop_front();
      if (do_wr) model_q.push_back(i_data);
      m_ovalid <= do_rd;
`ifdef FIFO_STICKY_ERR_EN
      m_ovf <= ov_ev || (m_ovf && !err_clr);
      m_udf <= un_ev || (m_udf && !err_clr);
`else
      m_ovf <= ov_ev;
      m_udf <= un_ev;
`endif
    end
  end

  // Single compare process, sampling on the inactive edge.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic int sz = model_q.size();
      check("count",   32'(count),   32'(sz));
      check("full",    32'(full),    32'(sz == DEPTH));
      check("empty",   32'(empty),   32'(sz == 0));
      check("afull",   32'(afull),   32'(sz >= AFT));
      check("aempty",  32'(aempty),  32'(sz <= AET));
      check("o_valid", 32'(o_valid), 32'(m_ovalid));
      check("o_data",  32'(o_data),  32'(m_odata));
      check("ovf",     32'(ovf),     32'(m_ovf));
      check("udf",     32'(udf),     32'(m_udf));
    end
  end

  // Drive for one cycle; returns 1 time unit after the edge.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    w_en = w; i_data = d; r_en = r; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst count",   32'(count),   0);
    check("rst empty",   32'(empty),   1);
    check("rst aempty",  32'(aempty),  1);
    check("rst full",    32'(full),    0);
    check("rst afull",   32'(afull),   0);
    check("rst o_valid", 32'(o_valid), 0);
    check("rst o_data",  32'(o_data),  0);

    // Fill with 0x11..0x55, then drain in order.
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
      if (i == 3) check("af at 3", 32'(afull), 1);
      if (i == 4) check("not full at 4", 32'(full), 0);
    end
    check("full at 5", 32'(full), 1);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain valid", 32'(o_valid), 1);
      check("drain data",  32'(o_data),  32'(i * 8'h11));
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("drained empty", 32'(empty),   1);
    check("valid drop",    32'(o_valid), 0);

    // Twelve write/read pairs wrap both pointers twice.
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap data", 32'(o_data), 32'(8'h60 + i));
    end

    // Overflow: full FIFO with simultaneous write/read.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    check("ovf count", 32'(count),  4);
    check("ovf flag",  32'(ovf),    1);
    check("ovf head",  32'(o_data), 32'h A0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef FIFO_STICKY_ERR_EN
    check("ovf sticky", 32'(ovf), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf cleared", 32'(ovf), 0);
`else
    check("ovf pulse", 32'(ovf), 0);
`endif
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("post-ovf data", 32'(o_data), 32'(8'hA0 + i));
    end

    // Underflow: empty FIFO with simultaneous write/read.
    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    check("udf flag",  32'(udf),     1);
    check("udf count", 32'(count),   1);
    check("udf valid", 32'(o_valid), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf word",  32'(o_data),  32'h3C);
    check("udf rd ok", 32'(o_valid), 1);
`ifdef FIFO_STICKY_ERR_EN
    check("udf sticky", 32'(udf), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
`else
    check("udf pulse", 32'(udf), 0);
`endif

    // Asynchronous reset mid-operation at COUNT=3.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hC1 + i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre-rst count", 32'(count), 3);
    #1 rst_n = 1'b0;
    #1;
    check("arst count",   32'(count),   0);
    check("arst empty",   32'(empty),   1);
    check("arst aempty",  32'(aempty),  1);
    check("arst afull",   32'(afull),   0);
    check("arst o_valid", 32'(o_valid), 0);
    check("arst o_data",  32'(o_data),  0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("post-rst udf",   32'(udf),     1);
    check("post-rst valid", 32'(o_valid), 0);

    // Randomized phases with shifting write/read bias to hit both extremes.
    for (int ph = 0; ph < 12; ph++) begin
      automatic int wb = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      for (int k = 0; k < 200; k++) begin
        cyc(1'($urandom_range(0, 99) < wb), 8'($urandom), 1'($urandom_range(0, 99) < (100 - wb)),
            1'($urandom_range(0, 9) == 0));
      end
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
